pipeline_hazard_ctrl: RTL and testbench

//  Central flush/stall sequencer for the 3-stage RV32I pipeline. Resolves branches and jumps in EX and

---
 rtl/pipeline_hazard_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central flush/stall sequencer for the 3-stage RV32I pipeline. Resolves branches and jumps
//   in EX, drives the PC redirect and a FLUSH_DEPTH-cycle wrong-path squash window, and
//   sequences load-use stalls (hold PC + IF/ID, bubble into EX).
//
// Parameters
//   FLUSH_DEPTH     cycles squash stays high after a taken redirect (1..7)
//   LOAD_USE_STALL  stall cycles inserted per load-use hazard (1..7)
//
// Optional feature macro: HAZARD_STATS_EN (adds redirect/stall event counters; when undefined
// the counter outputs are tied to zero).
//
// Ports
//   clk              clock
//   rst              synchronous, active-high reset
//   i_hold           global freeze: FSM, counters and registered outputs keep their value
//   i_ex_valid       EX holds a real (non-bubble) instruction
//   i_ex_inst        instruction in EX (opcode [6:2], funct3 [14:12])
//   i_br_eq          rs1 == rs2 from branch comparator
//   i_br_lt          rs1 < rs2 (signedness per funct3)
//   i_ld_use_hazard  load in EX feeds a source of the instruction in ID
//   o_pc_sel         select redirect target for next PC (registered)
//   o_squash         kill writes/stores of instructions in IF/ID/EX (registered)
//   o_stall_pc       hold PC and IF/ID register
//   o_bubble_ex      inject NOP into EX
//   o_br_illegal     valid branch with reserved funct3 010/011
//   o_flush_count    taken-redirect count (HAZARD_STATS_EN only, else 0)
//   o_stall_count    stall cycles asserted (HAZARD_STATS_EN only, else 0)

module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_DEPTH    = 3,
    parameter int unsigned LOAD_USE_STALL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_hold,
    input  logic        i_ex_valid,
    input  logic [31:0] i_ex_inst,
    input  logic        i_br_eq,
    input  logic        i_br_lt,
    input  logic        i_ld_use_hazard,
    output logic        o_pc_sel,
    output logic        o_squash,
    output logic        o_stall_pc,
    output logic        o_bubble_ex,
    output logic        o_br_illegal,
    output logic [31:0] o_flush_count,
    output logic [31:0] o_stall_count
);

    localparam logic [4:0] OpcBranch = 5'b11000;
    localparam logic [4:0] OpcJal    = 5'b11011;
    localparam logic [4:0] OpcJalr   = 5'b11001;

    localparam logic [2:0] FlushInit  = 3'(FLUSH_DEPTH - 1);
    // Only meaningful when LOAD_USE_STALL > 1; the first stall cycle comes from RUN itself.
    localparam logic [2:0] StallInit  = 3'(LOAD_USE_STALL - 2);
    localparam bit         StallMulti = (LOAD_USE_STALL > 1);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StFlush = 2'd1,
        StStall = 2'd2
    } state_t;

    state_t     r_state;
    logic [2:0] r_cnt;
    logic       r_redirect;
    logic       r_squash;

    logic [4:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_is_branch;
    logic       w_is_jump;
    logic       w_cond;
    logic       w_live;
    logic       w_taken;
    logic       w_stall;
    logic       w_unused;

    assign w_opcode    = i_ex_inst[6:2];
    assign w_funct3    = i_ex_inst[14:12];
    assign w_is_branch = (w_opcode == OpcBranch);
    assign w_is_jump   = (w_opcode == OpcJal) || (w_opcode == OpcJalr);

    // Fields of the instruction this block does not decode.
    assign w_unused = ^{i_ex_inst[31:15], i_ex_inst[11:7], i_ex_inst[1:0]};

    always_comb begin
        w_cond = 1'b0;
        case (w_funct3)
            3'b000:         w_cond = i_br_eq;
            3'b001:         w_cond = ~i_br_eq;
            3'b100, 3'b110: w_cond = i_br_lt;
            3'b101, 3'b111: w_cond = ~i_br_lt;
            default:        w_cond = 1'b0;
        endcase
    end

    // Squashed instructions are wrong-path and hold blocks any new detection.
    assign w_live  = i_ex_valid & ~r_squash & ~i_hold;
    assign w_taken = w_live & (w_is_jump | (w_is_branch & w_cond));

    assign o_br_illegal = w_live & w_is_branch & (w_funct3[2:1] == 2'b01);

    // First stall cycle is raised combinationally from RUN; the rest come from STALL.
    assign w_stall = ((r_state == StRun) & i_ld_use_hazard & ~w_taken & ~i_hold)
                   | (r_state == StStall);

    assign o_stall_pc  = w_stall;
    assign o_bubble_ex = w_stall;
    assign o_pc_sel    = r_redirect;
    assign o_squash    = r_squash;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StRun;
            r_cnt      <= 3'd0;
            r_redirect <= 1'b0;
            r_squash   <= 1'b0;
        end else if (!i_hold) begin
            r_redirect <= w_taken;
            if (w_taken) begin
                // A redirect also aborts an in-progress stall.
                r_state  <= StFlush;
                r_cnt    <= FlushInit;
                r_squash <= 1'b1;
            end else begin
                case (r_state)
                    StRun: begin
                        if (i_ld_use_hazard && StallMulti) begin
                            r_state <= StStall;
                            r_cnt   <= StallInit;
                        end
                    end
                    StFlush: begin
                        if (r_cnt == 3'd0) begin
                            r_state  <= StRun;
                            r_squash <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 3'd1;
                        end
                    end
                    StStall: begin
                        if (r_cnt == 3'd0) begin
                            r_state <= StRun;
                        end else begin
                            r_cnt <= r_cnt - 3'd1;
                        end
                    end
                    default: begin
                        r_state  <= StRun;
                        r_cnt    <= 3'd0;
                        r_squash <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_flush_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_count <= 32'd0;
            r_stall_count <= 32'd0;
        end else if (!i_hold) begin
            r_flush_count <= r_flush_count + 32'(w_taken);
            r_stall_count <= r_stall_count + 32'(w_stall);
        end
    end

    assign o_flush_count = r_flush_count;
    assign o_stall_count = r_stall_count;
`else
    assign o_flush_count = 32'd0;
    assign o_stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a window-counting model.

module tb_pipeline_hazard_ctrl;

    localparam int unsigned FD  = 3;
    localparam int unsigned LUS = 3;

    localparam logic [4:0] OPC_BR   = 5'b11000;
    localparam logic [4:0] OPC_JAL  = 5'b11011;
    localparam logic [4:0] OPC_JALR = 5'b11001;
    localparam logic [4:0] OPC_ALU  = 5'b01100;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        ex_valid;
    logic [31:0] ex_inst;
    logic        br_eq;
    logic        br_lt;
    logic        ld_use;
    logic        pc_sel;
    logic        squash;
    logic        stall_pc;
    logic        bubble_ex;
    logic        br_illegal;
    logic [31:0] flush_count;
    logic [31:0] stall_count;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .FLUSH_DEPTH    (FD),
        .LOAD_USE_STALL (LUS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_hold          (hold),
        .i_ex_valid      (ex_valid),
        .i_ex_inst       (ex_inst),
        .i_br_eq         (br_eq),
        .i_br_lt         (br_lt),
        .i_ld_use_hazard (ld_use),
        .o_pc_sel        (pc_sel),
        .o_squash        (squash),
        .o_stall_pc      (stall_pc),
        .o_bubble_ex     (bubble_ex),
        .o_br_illegal    (br_illegal),
        .o_flush_count   (flush_count),
        .o_stall_count   (stall_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: remaining squash cycles, remaining extra stall cycles, pending redirect, counters.
    int          m_sq_left = 0;
    int          m_st_left = 0;
    bit          m_redir   = 1'b0;
    logic [31:0] m_fc      = 32'd0;
    logic [31:0] m_sc      = 32'd0;

    logic        obs_pc_sel;
    logic        obs_squash;
    logic        obs_stall;
    logic        obs_illegal;
    logic [31:0] obs_fc;

    function automatic logic [31:0] mk(input logic [4:0] opc, input logic [2:0] f3);
        logic [16:0] hi;
        logic [4:0]  rd;
        hi = 17'($urandom);
        rd = 5'($urandom);
        return {hi, f3, rd, opc, 2'b11};
    endfunction

    function automatic bit resolves_taken(input logic [31:0] inst, input bit eq, input bit lt);
        if (inst[6:2] == OPC_JAL || inst[6:2] == OPC_JALR) return 1'b1;
        if (inst[6:2] != OPC_BR) return 1'b0;
        case (inst[14:12])
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] inst, input bit eq, input bit lt,
                         input bit ld, input bit hld);
        ex_valid = v;
        ex_inst  = inst;
        br_eq    = eq;
        br_lt    = lt;
        ld_use   = ld;
        hold     = hld;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Called just after the negedge input drive: compare, then advance the model over the edge.
    task automatic cycle();
        bit          in_sq;
        bit          taken;
        bit          ill;
        bit          st;
        logic [31:0] efc;
        logic [31:0] esc;
        #1;
        in_sq = (m_sq_left > 0);
        taken = ex_valid && !in_sq && !hold && resolves_taken(ex_inst, br_eq, br_lt);
        ill   = ex_valid && !in_sq && !hold && (ex_inst[6:2] == OPC_BR)
                && (ex_inst[14:13] == 2'b01);
        st    = (m_st_left > 0) || (!in_sq && ld_use && !taken && !hold);
`ifdef HAZARD_STATS_EN
        efc = m_fc;
        esc = m_sc;
`else
        efc = 32'd0;
        esc = 32'd0;
`endif
        check("pc_sel", {31'd0, pc_sel}, {31'd0, m_redir});
        check("squash", {31'd0, squash}, {31'd0, in_sq});
        check("stall_pc", {31'd0, stall_pc}, {31'd0, st});
        check("bubble_ex", {31'd0, bubble_ex}, {31'd0, st});
        check("br_illegal", {31'd0, br_illegal}, {31'd0, ill});
        check("flush_count", flush_count, efc);
        check("stall_count", stall_count, esc);
        obs_pc_sel  = pc_sel;
        obs_squash  = squash;
        obs_stall   = stall_pc;
        obs_illegal = br_illegal;
        obs_fc      = flush_count;
        @(posedge clk);
        if (rst) begin
            m_sq_left = 0;
            m_st_left = 0;
            m_redir   = 1'b0;
            m_fc      = 32'd0;
            m_sc      = 32'd0;
        end else if (!hold) begin
            m_redir = taken;
            m_fc    = m_fc + 32'(taken);
            m_sc    = m_sc + 32'(st);
            if (taken) begin
                m_sq_left = int'(FD);
                m_st_left = 0;
            end else if (m_sq_left > 0) begin
                m_sq_left--;
            end else if (m_st_left > 0) begin
                m_st_left--;
            end else if (ld_use) begin
                m_st_left = int'(LUS) - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        @(negedge clk);

        // Reset state.
        cycle();
        lit("reset_pc_sel", obs_pc_sel, 1'b0);
        lit("reset_squash", obs_squash, 1'b0);
        lit("reset_stall", obs_stall, 1'b0);
        rst = 1'b0;

        // Taken BEQ: pc_sel only at N+1, squash N+1..N+3.
        drive(1'b1, mk(OPC_BR, 3'd0), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        lit("beq_n_pc_sel", obs_pc_sel, 1'b0);
        idle();
        cycle();
        lit("beq_n1_pc_sel", obs_pc_sel, 1'b1);
        lit("beq_n1_squash", obs_squash, 1'b1);
        cycle();
        lit("beq_n2_pc_sel", obs_pc_sel, 1'b0);
        lit("beq_n2_squash", obs_squash, 1'b1);
        cycle();
        lit("beq_n3_squash", obs_squash, 1'b1);
        cycle();
        lit("beq_n4_squash", obs_squash, 1'b0);

        // Not-taken BNE then BLTU.
        drive(1'b1, mk(OPC_BR, 3'd1), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, mk(OPC_BR, 3'd6), 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        lit("bne_pc_sel", obs_pc_sel, 1'b0);
        idle();
        cycle();
        lit("bltu_pc_sel", obs_pc_sel, 1'b0);
        lit("bltu_squash", obs_squash, 1'b0);

        // JALR taken regardless of comparator inputs.
        drive(1'b1, mk(OPC_JALR, 3'($urandom)), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        cycle();
        idle();
        cycle();
        lit("jalr_pc_sel", obs_pc_sel, 1'b1);
        repeat (3) cycle();

        // One-cycle load-use hazard -> LUS stall cycles.
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        lit("lu_stall0", obs_stall, 1'b1);
        idle();
        cycle();
        lit("lu_stall1", obs_stall, 1'b1);
        cycle();
        lit("lu_stall2", obs_stall, 1'b1);
        cycle();
        lit("lu_stall3", obs_stall, 1'b0);

        // Taken + hazard together, then hazard during the flush window.
        drive(1'b1, mk(OPC_JAL, 3'd0), 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        lit("both_stall", obs_stall, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        lit("both_pc_sel", obs_pc_sel, 1'b1);
        lit("flush_lu_stall1", obs_stall, 1'b0);
        cycle();
        lit("flush_lu_stall2", obs_stall, 1'b0);
        idle();
        repeat (2) cycle();

        // Hold for two cycles mid-flush stretches the squash window by two.
        drive(1'b1, mk(OPC_JAL, 3'd0), 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        idle();
        cycle();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
        cycle();
        lit("hold_pc_sel", obs_pc_sel, 1'b0);
        lit("hold_squash", obs_squash, 1'b1);
        idle();
        cycle();
        cycle();
        lit("hold_n5_squash", obs_squash, 1'b1);
        cycle();
        lit("hold_n6_squash", obs_squash, 1'b0);

        // Reset in the middle of a flush.
        drive(1'b1, mk(OPC_JAL, 3'd0), 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        lit("rst_flush_squash", obs_squash, 1'b0);
        lit("rst_flush_pc_sel", obs_pc_sel, 1'b0);
        lit("rst_flush_stall", obs_stall, 1'b0);

        // Reserved branch funct3.
        drive(1'b1, mk(OPC_BR, 3'd2), 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        lit("illegal_pulse", obs_illegal, 1'b1);
        idle();
        cycle();
        lit("illegal_clear", obs_illegal, 1'b0);
        lit("illegal_no_redirect", obs_pc_sel, 1'b0);

        // Five redirects from a clean reset.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (5) begin
            drive(1'b1, mk(OPC_JAL, 3'd0), 1'b0, 1'b0, 1'b0, 1'b0);
            cycle();
            idle();
            repeat (3) cycle();
        end
        cycle();
`ifdef HAZARD_STATS_EN
        check("five_taken_count", obs_fc, 32'd5);
`else
        check("five_taken_count", obs_fc, 32'd0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            logic [4:0] opc;
            case ($urandom_range(0, 3))
                0:       opc = OPC_JAL;
                1:       opc = OPC_JALR;
                2:       opc = OPC_ALU;
                default: opc = OPC_BR;
            endcase
            rst = ($urandom_range(0, 199) == 0);
            drive(($urandom_range(0, 1) == 1), mk(opc, 3'($urandom)), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            cycle();
        end
        rst = 1'b0;
        idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
